// File: rtl/tow_pkg.sv
// tow_pkg: shared definitions for the tug-of-war round controller.
//   - FSM state encodings for tow_referee
//   - LFSR feedback tap mask and a one-step helper
//   - default parameter values shared with the score register and the top level
package tow_pkg;

  // Round controller states
  localparam logic [1:0] StDark  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StLock  = 2'd2;
  localparam logic [1:0] StOver  = 2'd3;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7,5,4,3
  localparam logic [7:0] LfsrTaps = 8'hB8;

  localparam int unsigned     DarkMinDflt      = 4;
  localparam int unsigned     DarkRandBitsDflt = 2;
  localparam int unsigned     LockCyclesDflt   = 3;
  localparam logic [7:0]      LfsrSeedDflt     = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LfsrTaps)};
  endfunction

endpackage

// File: rtl/tow_lfsr.sv
// tow_lfsr: 8-bit Fibonacci LFSR used to randomise the dark-phase length.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset, loads SEED
//   i_en     advance enable
//   o_state  current LFSR value (never all-zero for a nonzero SEED)
module tow_lfsr
  import tow_pkg::*;
#(
  parameter logic [7:0] SEED = LfsrSeedDflt
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic [7:0] o_state
);

  logic [7:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/tow_referee.sv
// tow_referee: round controller for the tug-of-war game.
// Runs a pseudo-random dark phase, arms the round, arbitrates the first press,
// penalises early presses and emits one-cycle move pulses. Freezes on game over.
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_pbl/i_pbr  synchronized left/right buttons (level)
//   i_game_over  score register shows a win
//   o_mv_l       one-cycle pulse: left scores
//   o_mv_r       one-cycle pulse: right scores
//   o_dark       display must be blanked
//   o_armed      round is live
module tow_referee
  import tow_pkg::*;
#(
  parameter int unsigned DARK_MIN       = DarkMinDflt,
  parameter int unsigned DARK_RAND_BITS = DarkRandBitsDflt,
  parameter int unsigned LOCK_CYCLES    = LockCyclesDflt,
  parameter logic [7:0]  LFSR_SEED      = LfsrSeedDflt
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pbl,
  input  logic i_pbr,
  input  logic i_game_over,
  output logic o_mv_l,
  output logic o_mv_r,
  output logic o_dark,
  output logic o_armed
);

  localparam logic [7:0] RandMask  = 8'((1 << DARK_RAND_BITS) - 1);
  localparam logic [7:0] DarkBase  = 8'(DARK_MIN);
  localparam logic [7:0] ResetLoad = DarkBase + (LFSR_SEED & RandMask);
  localparam logic [7:0] LockLoad  = 8'(LOCK_CYCLES);

  logic [7:0] w_lfsr;
  logic [7:0] w_reload;
  logic       w_evl, w_evr, w_any_ev;

  logic [1:0] r_state, w_state_d;
  logic [7:0] r_timer, w_timer_d;
  logic [7:0] r_lock, w_lock_d;
  logic       r_pbl_q, r_pbr_q;
  logic       r_mv_l, w_mv_l_d;
  logic       r_mv_r, w_mv_r_d;
  logic       r_dark, w_dark_d;
  logic       r_armed, w_armed_d;

  tow_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  // Reload uses the LFSR value present at the reload edge
  assign w_reload = DarkBase + (w_lfsr & RandMask);

  assign w_evl    = i_pbl & ~r_pbl_q;
  assign w_evr    = i_pbr & ~r_pbr_q;
  assign w_any_ev = w_evl | w_evr;

  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_lock_d  = r_lock;
    w_mv_l_d  = 1'b0;
    w_mv_r_d  = 1'b0;
    if (i_game_over) begin
      w_state_d = StOver;
    end else begin
      unique case (r_state)
        StDark: begin
          // Any press here is early; it wins over the arming edge
          if (w_any_ev) begin
            w_timer_d = w_reload;
            w_mv_r_d  = w_evl & ~w_evr;
            w_mv_l_d  = w_evr & ~w_evl;
          end else if (r_timer == 8'd1) begin
            w_state_d = StArmed;
          end else begin
            w_timer_d = r_timer - 8'd1;
          end
        end
        StArmed: begin
          if (w_any_ev) begin
            w_mv_l_d  = w_evl & ~w_evr;
            w_mv_r_d  = w_evr & ~w_evl;
            w_state_d = StLock;
            w_lock_d  = LockLoad;
          end
        end
        StLock: begin
          if (r_lock == 8'd1) begin
            w_state_d = StDark;
            w_timer_d = w_reload;
          end else begin
            w_lock_d = r_lock - 8'd1;
          end
        end
        StOver: begin
          w_state_d = StOver;
        end
      endcase
    end
    // Outputs are registered decodes of the next state
    w_dark_d  = (w_state_d == StDark) | (w_state_d == StLock);
    w_armed_d = (w_state_d == StArmed);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StDark;
      r_timer <= ResetLoad;
      r_lock  <= LockLoad;
      // Buttons held through reset must be released before they count
      r_pbl_q <= 1'b1;
      r_pbr_q <= 1'b1;
      r_mv_l  <= 1'b0;
      r_mv_r  <= 1'b0;
      r_dark  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      r_lock  <= w_lock_d;
      r_pbl_q <= i_pbl;
      r_pbr_q <= i_pbr;
      r_mv_l  <= w_mv_l_d;
      r_mv_r  <= w_mv_r_d;
      r_dark  <= w_dark_d;
      r_armed <= w_armed_d;
    end
  end

  assign o_mv_l  = r_mv_l;
  assign o_mv_r  = r_mv_r;
  assign o_dark  = r_dark;
  assign o_armed = r_armed;

endmodule

// File: tb/tb_tow_referee.sv
// tb_tow_referee: directed self-checking bench for tow_referee (default parameters).
module tb_tow_referee;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pbl = 1'b0;
  logic pbr = 1'b0;
  logic game_over = 1'b0;
  logic mv_l, mv_r, dark, armed;

  int n_vec = 0;
  int n_mis = 0;

  logic [7:0] m_lfsr;

  tow_referee dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pbl       (pbl),
    .i_pbr       (pbr),
    .i_game_over (game_over),
    .o_mv_l      (mv_l),
    .o_mv_r      (mv_r),
    .o_dark      (dark),
    .o_armed     (armed)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, advancing every edge
  function automatic logic [7:0] nxt(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk) m_lfsr <= rst ? 8'hA5 : nxt(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // From the current negedge, count cycles with armed low, dark high and pulses
  task automatic run_to_armed(output int n, output int nl, output int nr, output int nd);
    n = 0; nl = 0; nr = 0; nd = 0;
    while (armed !== 1'b1 && n < 200) begin
      if (dark === 1'b1) nd++;
      if (mv_l === 1'b1) nl++;
      if (mv_r === 1'b1) nr++;
      n++;
      @(negedge clk);
    end
  endtask

  // One decision from ARMED, then the whole lockout + dark phase
  task automatic round(input string tag, input logic l, input logic r,
                       input int exp_l, input int exp_r);
    logic [7:0] v;
    int n, nl, nr, nd;
    pbl = l; pbr = r;
    @(negedge clk);
    pbl = 1'b0; pbr = 1'b0;
    chk({tag, "_armed_drop"}, 32'(armed), 0);
    v = nxt(nxt(m_lfsr));
    run_to_armed(n, nl, nr, nd);
    chk({tag, "_len"}, n, 7 + int'(v[1:0]));
    chk({tag, "_dark"}, nd, n);
    chk({tag, "_mvl"}, nl, exp_l);
    chk({tag, "_mvr"}, nr, exp_r);
  endtask

  // Reset, then press one button early in the dark phase
  task automatic jump(input string tag, input logic left);
    logic [7:0] v;
    int n, nl, nr, nd;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v = m_lfsr;
    if (left) pbl = 1'b1;
    else pbr = 1'b1;
    @(negedge clk);
    pbl = 1'b0; pbr = 1'b0;
    run_to_armed(n, nl, nr, nd);
    chk({tag, "_len"}, n, 4 + int'(v[1:0]));
    chk({tag, "_mvl"}, nl, left ? 0 : 1);
    chk({tag, "_mvr"}, nr, left ? 1 : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, nl, nr, nd, cl, cr;
    logic [7:0] v;

    // Reset release
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_dark", 32'(dark), 1);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_mvl", 32'(mv_l), 0);
    chk("rst_mvr", 32'(mv_r), 0);
    run_to_armed(n, nl, nr, nd);
    chk("rel_len", n, 5);
    chk("rel_dark", nd, 5);
    chk("rel_pulses", nl + nr, 0);
    chk("rel_dark_off", 32'(dark), 0);

    round("left", 1'b1, 1'b0, 1, 0);

    // Left first, right one cycle later lands in lockout
    pbl = 1'b1;
    @(negedge clk);
    chk("lr_mvl", 32'(mv_l), 1);
    v = nxt(nxt(m_lfsr));
    pbl = 1'b0; pbr = 1'b1;
    @(negedge clk);
    pbr = 1'b0;
    run_to_armed(n, nl, nr, nd);
    chk("lr_len", n, 6 + int'(v[1:0]));
    chk("lr_mvl_more", nl, 0);
    chk("lr_mvr", nr, 0);

    round("tie", 1'b1, 1'b1, 0, 0);
    round("right", 1'b0, 1'b1, 0, 1);

    // Hold left across rounds: one event only
    cl = 0; cr = 0;
    pbl = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mv_l === 1'b1) cl++;
      if (mv_r === 1'b1) cr++;
    end
    pbl = 1'b0;
    chk("hold_mvl", cl, 1);
    chk("hold_mvr", cr, 0);
    chk("hold_rearmed", 32'(armed), 1);

    jump("jg_r", 1'b0);
    jump("jg_l", 1'b1);

    // Game over freezes everything
    game_over = 1'b1;
    @(negedge clk);
    chk("go_armed", 32'(armed), 0);
    chk("go_dark", 32'(dark), 0);
    cl = 0;
    for (int i = 0; i < 8; i++) begin
      pbl = (i % 2) == 1;
      pbr = (i % 4) >= 2;
      if (i == 5) game_over = 1'b0;
      @(negedge clk);
      if (mv_l === 1'b1 || mv_r === 1'b1) cl++;
    end
    pbl = 1'b0; pbr = 1'b0;
    chk("go_pulses", cl, 0);
    chk("go_sticky_armed", 32'(armed), 0);
    chk("go_sticky_dark", 32'(dark), 0);

    // Reset with left held: no event until released and pressed again
    pbl = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_to_armed(n, nl, nr, nd);
    chk("rh_len", n, 5);
    chk("rh_pulses", nl + nr, 0);
    repeat (5) @(negedge clk);
    chk("rh_still_armed", 32'(armed), 1);
    pbl = 1'b0;
    @(negedge clk);
    pbl = 1'b1;
    @(negedge clk);
    chk("rh_repress_mvl", 32'(mv_l), 1);
    pbl = 1'b0;

    // Reset coinciding with a decisive press suppresses the pulse
    run_to_armed(n, nl, nr, nd);
    chk("rp_armed", 32'(armed), 1);
    pbl = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rp_mvl_rst", 32'(mv_l), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rp_mvl_after", 32'(mv_l), 0);
    chk("rp_dark", 32'(dark), 1);
    pbl = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
